// File: rtl/dec_onehot_scan_pkg.sv
// Shared constants and helpers for the one-hot decoder / display scanner.
//   MODE_DIRECT / MODE_SCAN : values of the 'mode' input
//   MAX_SEL_W / MAX_OUT_W   : widest legal select / output (SEL_W <= 6)
//   onehot()                : 1 << sel at maximum output width; callers truncate
package dec_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int unsigned MAX_SEL_W = 6;
  localparam int unsigned MAX_OUT_W = 2 ** MAX_SEL_W;

  // One-hot of a select value, sized for the widest configuration.
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    return MAX_OUT_W'(1) << sel;
  endfunction

endpackage

// File: rtl/dec_onehot_scan_if.sv
// Control/select bus between the controlling logic and dec_onehot_scan.
//   e, mode, sel, dwell : driven by the controller (master)
//   y, idx, wrap        : driven by the decoder (slave)
interface dec_onehot_scan_if #(
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL_W = 8
);

  localparam int unsigned OUT_W = 2 ** SEL_W;

  logic               e;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   y;
  logic [SEL_W-1:0]   idx;
  logic               wrap;

  modport master (
    output e, mode, sel, dwell,
    input  y, idx, wrap
  );

  modport slave (
    input  e, mode, sel, dwell,
    output y, idx, wrap
  );

endinterface

// File: rtl/dec_onehot_scan_dwell_timer.sv
// Dwell counter for auto-scan: counts cycles spent on the current index and
// flags when the scan must step to the next one.
//   clk, rst : clock, synchronous active-high reset
//   e        : enable; low holds the counter
//   mode     : direct mode clears the counter so scan starts fresh
//   dwell    : cycles per step minus one, sampled live
//   step_c   : combinational, high in the cycle the index advances at the edge
module dec_dwell_timer
  import dec_pkg::*;
#(
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned BLANK   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               e,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic               step_c
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] limit_c;

  // With blanking, every step needs at least one visible cycle after the blank.
  always_comb begin
    limit_c = dwell;
    if ((BLANK != 0) && (dwell == '0)) begin
      limit_c = DWELL_W'(1);
    end
  end

  // >= rather than == so a lowered dwell steps immediately instead of wrapping.
  always_comb begin
    cnt_d  = cnt_q;
    step_c = 1'b0;
    if (e) begin
      if (mode == MODE_DIRECT) begin
        cnt_d = '0;
      end else if (cnt_q >= limit_c) begin
        cnt_d  = '0;
        step_c = 1'b1;
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dec_onehot_scan.sv
// Registered N-to-2^N one-hot decoder with enable and auto-scan mode for
// multiplexed display rows/digits and keypad matrices.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of dec_onehot_scan_if
//              e     - enable (low: y=0, index and dwell count frozen)
//              mode  - 0 direct decode of sel, 1 auto-scan
//              sel   - direct-mode select
//              dwell - scan cycles per index minus one
//              y     - registered one-hot output
//              idx   - registered current index
//              wrap  - one-cycle pulse when the scan returns to index 0
module dec_onehot_scan
  import dec_pkg::*;
#(
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned BLANK   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  dec_onehot_scan_if.slave     bus
);

  localparam int unsigned OUT_W = 2 ** SEL_W;

  logic [OUT_W-1:0] y_q, y_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic             step_c;
  logic [SEL_W-1:0] idx_nxt_c;

  dec_dwell_timer #(
    .DWELL_W (DWELL_W),
    .BLANK   (BLANK)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .e      (bus.e),
    .mode   (bus.mode),
    .dwell  (bus.dwell),
    .step_c (step_c)
  );

  // OUT_W is a power of two, so the natural SEL_W overflow is the modulo wrap.
  assign idx_nxt_c = idx_q + SEL_W'(1);

  // Next index/output/wrap; disabled cycles keep idx and drive y low.
  always_comb begin
    idx_d  = idx_q;
    y_d    = '0;
    wrap_d = 1'b0;
    if (bus.e) begin
      if (bus.mode == MODE_DIRECT) begin
        idx_d = bus.sel;
        y_d   = OUT_W'(onehot(MAX_SEL_W'(bus.sel)));
      end else if (step_c) begin
        idx_d  = idx_nxt_c;
        wrap_d = (idx_q == SEL_W'(OUT_W - 1));
        // Blanking inserts one dark cycle so two select lines never overlap.
        if (BLANK == 0) begin
          y_d = OUT_W'(onehot(MAX_SEL_W'(idx_nxt_c)));
        end
      end else begin
        y_d = OUT_W'(onehot(MAX_SEL_W'(idx_q)));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_dec_onehot_scan.sv
// Self-checking bench for dec_onehot_scan: one instance without blanking (a)
// and one with blanking (b), both SEL_W=2, DWELL_W=8, driven by the same inputs
// and compared every cycle against a behavioural model, plus table vectors and
// hand-written corner-case sequences.
module tb_dec_onehot_scan;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  dec_onehot_scan_if #(.SEL_W(2), .DWELL_W(8)) ifa ();
  dec_onehot_scan_if #(.SEL_W(2), .DWELL_W(8)) ifb ();

  dec_onehot_scan #(.SEL_W(2), .DWELL_W(8), .BLANK(0)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa.slave)
  );
  dec_onehot_scan #(.SEL_W(2), .DWELL_W(8), .BLANK(1)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state, index 0 = no blanking, 1 = blanking.
  int m_idx [2];
  int m_cnt [2];
  int m_y   [2];
  int m_wrap[2];

  logic       in_e, in_mode;
  logic [1:0] in_sel;
  logic [7:0] in_dwell;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic e, input logic mode,
                        input logic [1:0] sel, input logic [7:0] dwell);
    rst = r; in_e = e; in_mode = mode; in_sel = sel; in_dwell = dwell;
    ifa.e = e; ifa.mode = mode; ifa.sel = sel; ifa.dwell = dwell;
    ifb.e = e; ifb.mode = mode; ifb.sel = sel; ifb.dwell = dwell;
  endtask

  // Rules: reset clears, disable darkens and freezes, direct decodes sel,
  // scan holds each index for limit+1 cycles then moves on.
  task automatic model_step();
    for (int b = 0; b < 2; b++) begin
      int lim;
      if (rst) begin
        m_idx[b] = 0; m_cnt[b] = 0; m_y[b] = 0; m_wrap[b] = 0;
      end else if (!in_e) begin
        m_y[b] = 0; m_wrap[b] = 0;
      end else if (!in_mode) begin
        m_idx[b] = int'(in_sel); m_cnt[b] = 0; m_y[b] = 1 << in_sel; m_wrap[b] = 0;
      end else begin
        lim = int'(in_dwell);
        if (b == 1 && lim < 1) lim = 1;
        if (m_cnt[b] < lim) begin
          m_cnt[b]++;
          m_y[b] = 1 << m_idx[b];
          m_wrap[b] = 0;
        end else begin
          m_cnt[b]  = 0;
          m_wrap[b] = (m_idx[b] == 3) ? 1 : 0;
          m_idx[b]  = (m_idx[b] + 1) % 4;
          m_y[b]    = (b == 1) ? 0 : (1 << m_idx[b]);
        end
      end
    end
  endtask

  // One clock: model advances with the edge, outputs sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("a_y",    int'(ifa.y),    m_y[0]);
    chk("a_idx",  int'(ifa.idx),  m_idx[0]);
    chk("a_wrap", int'(ifa.wrap), m_wrap[0]);
    chk("b_y",    int'(ifb.y),    m_y[1]);
    chk("b_idx",  int'(ifb.idx),  m_idx[1]);
    chk("b_wrap", int'(ifb.wrap), m_wrap[1]);
    chk("a_onehot", ($countones(ifa.y) <= 1) ? 1 : 0, 1);
    chk("b_onehot", ($countones(ifb.y) <= 1) ? 1 : 0, 1);
  endtask

  typedef struct {
    logic       rst;
    logic       e;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] y;
    logic [1:0] idx;
    logic       wrap;
  } vec_t;

  vec_t tbl[9];

  initial begin
    errors = 0;
    checks = 0;
    for (int b = 0; b < 2; b++) begin
      m_idx[b] = 0; m_cnt[b] = 0; m_y[b] = 0; m_wrap[b] = 0;
    end

    // Reset with scan requested, then direct decode, then disable.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 2'd0, 4'b0000, 2'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 2'd0, 4'b0000, 2'd0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 2'd0, 4'b0000, 2'd0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 2'd2, 4'b0100, 2'd2, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 2'd3, 4'b1000, 2'd3, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd3, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 2'd3, 1'b0};

    set_in(1'b1, 1'b1, 1'b1, 2'd0, 8'd0);
    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].rst, tbl[i].e, tbl[i].mode, tbl[i].sel, 8'd0);
      cyc();
      chk("tbl_a_y",    int'(ifa.y),    int'(tbl[i].y));
      chk("tbl_a_idx",  int'(ifa.idx),  int'(tbl[i].idx));
      chk("tbl_a_wrap", int'(ifa.wrap), int'(tbl[i].wrap));
      chk("tbl_b_y",    int'(ifb.y),    int'(tbl[i].y));
    end

    // Scan dwell=2 without blanking: each index shown 3 cycles, wrap every 12.
    set_in(1'b0, 1'b1, 1'b0, 2'd0, 8'd2);
    cyc();
    for (int k = 1; k <= 25; k++) begin
      set_in(1'b0, 1'b1, 1'b1, 2'd0, 8'd2);
      cyc();
      chk("scan3_y",    int'(ifa.y),    1 << ((k / 3) % 4));
      chk("scan3_wrap", int'(ifa.wrap), (k % 12 == 0) ? 1 : 0);
    end

    // Blanking with dwell=0: effective limit 1, dark cycle between indices.
    set_in(1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
    cyc();
    for (int k = 1; k <= 12; k++) begin
      set_in(1'b0, 1'b1, 1'b1, 2'd0, 8'd0);
      cyc();
      if (k == 1) chk("blank0_y", int'(ifb.y), 1);
      else if (k % 2 == 0) chk("blank0_y", int'(ifb.y), 0);
      else chk("blank0_y", int'(ifb.y), 1 << (((k - 1) / 2) % 4));
    end
    // Blanking with dwell=3: one dark cycle then three lit cycles per step.
    for (int k = 0; k < 16; k++) begin
      set_in(1'b0, 1'b1, 1'b1, 2'd0, 8'd3);
      cyc();
    end

    // Freeze/resume: dwell=4 at idx 1, drop e at cnt=2 for 5 cycles.
    set_in(1'b0, 1'b1, 1'b0, 2'd1, 8'd4);
    cyc();
    set_in(1'b0, 1'b1, 1'b1, 2'd1, 8'd4);
    cyc();
    cyc();
    for (int k = 0; k < 5; k++) begin
      set_in(1'b0, 1'b0, 1'b1, 2'd1, 8'd4);
      cyc();
      chk("frz_y",   int'(ifa.y),   0);
      chk("frz_idx", int'(ifa.idx), 1);
    end
    set_in(1'b0, 1'b1, 1'b1, 2'd1, 8'd4);
    cyc();
    chk("resume1_y", int'(ifa.y), 2);
    cyc();
    chk("resume2_y", int'(ifa.y), 2);
    cyc();
    chk("resume3_y", int'(ifa.y), 4);
    chk("resume3_idx", int'(ifa.idx), 2);

    // dwell lowered 200 -> 1 at cnt=50: advance on the next edge.
    set_in(1'b0, 1'b1, 1'b0, 2'd0, 8'd200);
    cyc();
    for (int k = 0; k < 50; k++) begin
      set_in(1'b0, 1'b1, 1'b1, 2'd0, 8'd200);
      cyc();
    end
    chk("dw200_idx", int'(ifa.idx), 0);
    set_in(1'b0, 1'b1, 1'b1, 2'd0, 8'd1);
    cyc();
    chk("dwdrop_y",   int'(ifa.y),   2);
    chk("dwdrop_idx", int'(ifa.idx), 1);

    // Direct sel=2 then scan: scan starts from idx 2 with a fresh count.
    set_in(1'b0, 1'b1, 1'b0, 2'd2, 8'd2);
    cyc();
    set_in(1'b0, 1'b1, 1'b1, 2'd0, 8'd2);
    cyc();
    chk("m01_y",   int'(ifa.y),   4);
    chk("m01_idx", int'(ifa.idx), 2);

    // Reset mid-sweep at idx 3, then scan restarts at idx 0.
    set_in(1'b0, 1'b1, 1'b0, 2'd3, 8'd2);
    cyc();
    set_in(1'b0, 1'b1, 1'b1, 2'd0, 8'd2);
    cyc();
    set_in(1'b1, 1'b1, 1'b1, 2'd0, 8'd2);
    cyc();
    chk("rstmid_y",   int'(ifa.y),   0);
    chk("rstmid_idx", int'(ifa.idx), 0);
    set_in(1'b0, 1'b1, 1'b1, 2'd0, 8'd2);
    cyc();
    chk("rstscan_y",   int'(ifa.y),   1);
    chk("rstscan_idx", int'(ifa.idx), 0);

    // Randomised traffic against the model.
    for (int k = 0; k < 600; k++) begin
      logic r, e, m;
      logic [1:0] s;
      logic [7:0] d;
      r = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 9) != 0);
      m = (k % 80 < 60) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 1) != 0);
      s = 2'($urandom_range(0, 3));
      d = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255))
                                       : 8'($urandom_range(0, 4));
      set_in(r, e, m, s, d);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
